// File: rtl/riscv_pkg.sv
// Shared RV32 front-end constants, the IF/ID payload type and a PC increment helper.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   // Canonical bubble: addi x0, x0, 0
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [ILEN-1:0] instr;
   } if_id_t;

   // Sequential PC, wraps modulo 2^XLEN
   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a new fetch, flush inserts a bubble
// while keeping the PC fields, neither holds. Flush wins over load.
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            flush,
   input  logic            valid_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc4_in,
   input  logic [ILEN-1:0] instr_in,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   output logic [ILEN-1:0] instr
);

   if_id_t q;

   // Pipeline register update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q.valid <= 1'b0;
         q.pc    <= '0;
         q.pc4   <= '0;
         q.instr <= NOP_INSTR;
      end else if (flush) begin
         q.valid <= 1'b0;
         q.instr <= NOP_INSTR;
      end else if (load) begin
         q.valid <= valid_in;
         q.pc    <= pc_in;
         q.pc4   <= pc4_in;
         q.instr <= instr_in;
      end
   end

   assign valid = q.valid;
   assign pc    = q.pc;
   assign pc4   = q.pc4;
   assign instr = q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect/stall control, IF/ID register.
// FETCH_MISALIGN_CHECK_EN: when defined, a misaligned redirect target sets a
// sticky fetch_fault and suppresses valid fetches until reset; when undefined,
// redirect targets are word-aligned on load and fetch_fault is tied low.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::DEFAULT_RESET_PC,
   parameter logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   input  logic [ILEN-1:0] imem_data,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc4,
   output logic [ILEN-1:0] if_id_instr,
   output logic            fetch_fault
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc4_c;
   logic [XLEN-1:0] target_c;
   logic            fetch_ok_c;
   logic            load_c;

   assign pc4_c     = pc_plus4(pc_q);
   assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q;

   assign target_c   = redirect_pc;
   assign fetch_ok_c = ~fault_q;

   // Sticky fault on any redirect to a non-word-aligned target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
         fault_q <= 1'b1;
      end
   end

   assign fetch_fault = fault_q;
`else
   logic unused_low_bits;

   assign unused_low_bits = ^redirect_pc[1:0];
   assign target_c        = {redirect_pc[XLEN-1:2], 2'b00};
   assign fetch_ok_c      = 1'b1;
   assign fetch_fault     = 1'b0;
`endif

   // Next PC: redirect beats stall, otherwise advance by one word
   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = target_c;
      end else if (!stall) begin
         pc_d = pc4_c;
      end
   end

   // PC register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign load_c = ~redirect & ~stall;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .rst      (rst),
      .load     (load_c),
      .flush    (redirect),
      .valid_in (fetch_ok_c),
      .pc_in    (pc_q),
      .pc4_in   (pc4_c),
      .instr_in (imem_data),
      .valid    (if_id_valid),
      .pc       (if_id_pc),
      .pc4      (if_id_pc4),
      .instr    (if_id_instr)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .if_id_valid (if_id_valid),
      .if_id_pc    (if_id_pc),
      .if_id_pc4   (if_id_pc4),
      .if_id_instr (if_id_instr),
      .fetch_fault (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: word 0 is addi x1,x0,5; every other word is addr ^ C0DE_0000
   assign imem_data = (imem_addr == 32'h0) ? 32'h0050_0093 : (imem_addr ^ 32'hC0DE_0000);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic [31:0] addr);
      check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(v));
      check_eq({tag, ".pc"}, if_id_pc, pc);
      check_eq({tag, ".pc4"}, if_id_pc4, pc + 32'd4);
      check_eq({tag, ".instr"}, if_id_instr, ins);
      check_eq({tag, ".addr"}, imem_addr, addr);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      step();
      step();
      // Reset state
      check_eq("rst.addr", imem_addr, 32'h0);
      check_eq("rst.valid", 32'(if_id_valid), 32'h0);
      check_eq("rst.instr", if_id_instr, NOP);
      check_eq("rst.pc", if_id_pc, 32'h0);
      check_eq("rst.pc4", if_id_pc4, 32'h0);
      check_eq("rst.fault", 32'(fetch_fault), 32'h0);
      rst = 1'b0;

      // First fetch after release
      step();
      check_ifid("first", 1'b1, 32'h0, 32'h0050_0093, 32'h4);
      step();
      check_ifid("second", 1'b1, 32'h4, 32'hC0DE_0004, 32'h8);

      // Stall holds everything at pc=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 1'b1, 32'h4, 32'hC0DE_0004, 32'h8);
      end
      stall = 1'b0;
      step();
      check_ifid("unstall", 1'b1, 32'h8, 32'hC0DE_0008, 32'hC);

      // Redirect with simultaneous stall: redirect wins, pc fields hold
      redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
      step();
      check_ifid("redir", 1'b0, 32'h8, NOP, 32'h40);
      redirect = 1'b0; stall = 1'b0;
      step();
      check_ifid("redir_fetch", 1'b1, 32'h40, 32'hC0DE_0040, 32'h44);

      // Back-to-back redirects: only the last target is fetched
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      check_eq("redir2.addr", imem_addr, 32'h100);
      redirect_pc = 32'h200;
      step();
      check_ifid("redir3", 1'b0, 32'h40, NOP, 32'h200);
      redirect = 1'b0;
      step();
      check_ifid("redir3_fetch", 1'b1, 32'h200, 32'hC0DE_0200, 32'h204);

      // PC wrap at the top of the address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      check_eq("wrap.pre_addr", imem_addr, 32'hFFFF_FFFC);
      redirect = 1'b0;
      step();
      check_eq("wrap.addr", imem_addr, 32'h0);
      check_eq("wrap.pc4", if_id_pc4, 32'h0);
      check_eq("wrap.pc", if_id_pc, 32'hFFFF_FFFC);
      check_eq("wrap.instr", if_id_instr, 32'h3F21_FFFC);

      // Asynchronous reset between edges while mid-redirect/stall at pc=0x20
      redirect = 1'b1; redirect_pc = 32'h20;
      step();
      check_eq("pre_arst.addr", imem_addr, 32'h20);
      stall = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check_eq("arst.addr", imem_addr, 32'h0);
      check_eq("arst.valid", 32'(if_id_valid), 32'h0);
      check_eq("arst.instr", if_id_instr, NOP);
      check_eq("arst.pc", if_id_pc, 32'h0);
      check_eq("arst.pc4", if_id_pc4, 32'h0);
      #1;
      rst = 1'b0; redirect = 1'b0; stall = 1'b0;
      step();
      check_ifid("post_arst", 1'b1, 32'h0, 32'h0050_0093, 32'h4);

      // Misaligned redirect target
      redirect = 1'b1; redirect_pc = 32'h42;
      step();
`ifdef FETCH_MISALIGN_CHECK_EN
      check_eq("mis.addr", imem_addr, 32'h42);
      check_eq("mis.fault", 32'(fetch_fault), 32'h1);
`else
      check_eq("mis.addr", imem_addr, 32'h40);
      check_eq("mis.fault", 32'(fetch_fault), 32'h0);
`endif
      check_eq("mis.valid", 32'(if_id_valid), 32'h0);
      redirect = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
`ifdef FETCH_MISALIGN_CHECK_EN
         check_eq("mis_hold.valid", 32'(if_id_valid), 32'h0);
         check_eq("mis_hold.fault", 32'(fetch_fault), 32'h1);
`else
         check_eq("mis_hold.valid", 32'(if_id_valid), 32'h1);
         check_eq("mis_hold.pc", if_id_pc, 32'h40 + 32'(4 * i));
`endif
      end

      // Reset clears everything, including any fault
      rst = 1'b1;
      #1;
      check_eq("final_rst.fault", 32'(fetch_fault), 32'h0);
      check_eq("final_rst.addr", imem_addr, 32'h0);
      rst = 1'b0;
      step();
      check_eq("final.valid", 32'(if_id_valid), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction placed in IF/ID.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 stall  input  1  hold PC and IF/ID contents.
REQ-007 redirect  input  1  branch/jump taken; load redirect_pc, flush IF/ID.
REQ-008 redirect_pc  input  32  target address for redirect.
REQ-009 imem_addr  output  32  fetch address driven to instruction memory addr.
REQ-010 imem_data  input  32  instruction returned combinationally by instruction memory.
REQ-011 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-012 if_id_pc  output  32  PC of instruction in IF/ID.
REQ-013 if_id_pc4  output  32  if_id_pc + 4.
REQ-014 if_id_instr  output  32  instruction in IF/ID.
REQ-015 fetch_fault  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 imem_addr SHALL equal the PC register combinationally; no address registering.
REQ-017 Normal edge (redirect=0, stall=0): IF/ID <= {valid=1, pc, imem_data, pc+4}; pc <= pc+4.
REQ-018 Stall edge (redirect=0, stall=1): pc and all IF/ID outputs SHALL hold unchanged.
REQ-019 Redirect edge (redirect=1, any stall): pc <= redirect_pc; if_id_valid <= 0; if_id_instr <= NOP_INSTR; if_id_pc/if_id_pc4 hold.
REQ-020 redirect SHALL take priority over stall.
REQ-021 Fetch latency: instruction at address A SHALL appear on if_id_instr one edge after pc==A with stall=0, redirect=0.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-023 if_id_valid SHALL be 0 from reset until the first normal edge.
REQ-024 Consecutive redirects SHALL each load their target; only the last-cycle target is fetched.

Reset
REQ-025 rst=1 SHALL immediately force pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, fetch_fault=0.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL override both; first fetch after release is from RESET_PC.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHECK_EN SHALL select misalignment handling.
REQ-028 Defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset), loads pc, and keeps if_id_valid=0 on all subsequent edges until reset.
REQ-029 Undefined: redirect_pc[1:0] forced to 2'b00 on load; fetch_fault tied 0.

Structure
REQ-030 Shared package riscv_pkg SHALL hold XLEN=32, NOP_INSTR constant and default RESET_PC.
REQ-031 IF/ID register SHALL be a sub-module if_id_reg (load, flush, hold controls); PC logic stays in fetch_unit.

Verification
REQ-032 Reset release, stall=0, memory word0=32'h00500093: after 1 edge if_id_valid=1, if_id_pc=0, if_id_instr=32'h00500093, imem_addr=4.
REQ-033 stall=1 for 3 edges at pc=8: imem_addr stays 8, IF/ID unchanged; stall drop -> next edge if_id_pc=8.
REQ-034 redirect=1, redirect_pc=32'h40, stall=1 same cycle: next edge imem_addr=32'h40, if_id_valid=0, if_id_instr=NOP_INSTR; following edge if_id_pc=32'h40.
REQ-035 pc=32'hFFFF_FFFC, normal edge: imem_addr=0, if_id_pc4=0.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect_pc=32'h42: fetch_fault=1, if_id_valid stays 0 for 5 edges; without macro: imem_addr=32'h40, fetch_fault=0.
REQ-037 rst pulsed asynchronously between edges while pc=32'h20: outputs reach reset values before next edge; imem_addr=RESET_PC.
